// File: rtl/demux3_8_registrado_pkg.sv
// Shared constants and types for the registered 1-to-3 demux.
// Selector codes, data width and channel state encoding.
package demux3_8_registrado_pkg;

  localparam int LARGURA_DADO = 8;

  localparam logic [1:0] CANAL_0        = 2'b00;
  localparam logic [1:0] CANAL_1        = 2'b01;
  localparam logic [1:0] CANAL_2        = 2'b10;
  localparam logic [1:0] CANAL_INVALIDO = 2'b11;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

endpackage

// File: rtl/demux3_8_registrado_canal_buffer.sv
// One-entry channel buffer with valid/ready output side.
// Optional pop counter under DEMUX3_8_CONTADORES_EN.
module canal_buffer
  import demux3_8_registrado_pkg::*;
#(
  parameter int LARGURA = LARGURA_DADO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [LARGURA-1:0] data_in,
  input  logic               pop,
  output logic [LARGURA-1:0] data_out,
  output logic               valid
`ifdef DEMUX3_8_CONTADORES_EN
  ,
  output logic [7:0]         contagem
`endif
);

  estado_t estado;
  logic    pop_ok;

  assign pop_ok = pop && (estado == CHEIO);
  assign valid  = (estado == CHEIO);

  // Channel FSM: a write fills, a pop alone empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= VAZIO;
      data_out <= '0;
    end else if (wr_en) begin
      estado   <= CHEIO;
      data_out <= data_in;
    end else if (pop_ok) begin
      estado   <= VAZIO;
    end
  end

`ifdef DEMUX3_8_CONTADORES_EN
  // Count delivered values; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (pop_ok) begin
      contagem <= contagem + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/demux3_8_registrado.sv
// Registered 1-to-3 demux with per-channel one-entry buffers.
// Define DEMUX3_8_CONTADORES_EN to add per-channel pop counters.
module demux3_8_registrado
  import demux3_8_registrado_pkg::*;
#(
  parameter int LARGURA = LARGURA_DADO
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada,
  input  logic [1:0]         Controle,
  input  logic               EntradaValida,
  output logic               EntradaPronta,
  output logic [LARGURA-1:0] Saida0,
  output logic [LARGURA-1:0] Saida1,
  output logic [LARGURA-1:0] Saida2,
  output logic [2:0]         SaidaValida,
  input  logic [2:0]         SaidaPronta,
  output logic               ErroControle
`ifdef DEMUX3_8_CONTADORES_EN
  ,
  output logic [7:0]         Contagem0,
  output logic [7:0]         Contagem1,
  output logic [7:0]         Contagem2
`endif
);

  logic [2:0]         sel;
  logic [2:0]         wr;
  logic [2:0]         pop;
  logic [LARGURA-1:0] dados [3];
`ifdef DEMUX3_8_CONTADORES_EN
  logic [7:0]         contagens [3];
`endif

  // One-hot destination decode; invalid code selects nothing.
  always_comb begin
    sel = 3'b000;
    unique case (Controle)
      CANAL_0: sel = 3'b001;
      CANAL_1: sel = 3'b010;
      CANAL_2: sel = 3'b100;
      default: sel = 3'b000;
    endcase
  end

  // Only the addressed channel can stall the producer.
  assign EntradaPronta =
    (sel == 3'b000) ||
    (|(sel & (~SaidaValida | SaidaPronta)));

  assign wr  = (EntradaValida && EntradaPronta) ? sel : 3'b000;
  assign pop = SaidaValida & SaidaPronta;

  for (genvar i = 0; i < 3; i++) begin : g_canal
    canal_buffer #(.LARGURA(LARGURA)) u_canal (
      .clk      (Clock),
      .rst_n    (Reset),
      .wr_en    (wr[i]),
      .data_in  (Entrada),
      .pop      (pop[i]),
      .data_out (dados[i]),
      .valid    (SaidaValida[i])
`ifdef DEMUX3_8_CONTADORES_EN
      ,
      .contagem (contagens[i])
`endif
    );
  end

  assign Saida0 = dados[0];
  assign Saida1 = dados[1];
  assign Saida2 = dados[2];

`ifdef DEMUX3_8_CONTADORES_EN
  assign Contagem0 = contagens[0];
  assign Contagem1 = contagens[1];
  assign Contagem2 = contagens[2];
`endif

  // Sticky flag for offers carrying the invalid selector.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ErroControle <= 1'b0;
    end else if (EntradaValida && Controle == CANAL_INVALIDO) begin
      ErroControle <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux3_8_registrado.sv
// Directed bench for demux3_8_registrado.
// Counter checks run when DEMUX3_8_CONTADORES_EN is defined.
module tb_demux3_8_registrado;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Entrada;
  logic [1:0] Controle;
  logic       EntradaValida;
  logic       EntradaPronta;
  logic [7:0] Saida0, Saida1, Saida2;
  logic [2:0] SaidaValida;
  logic [2:0] SaidaPronta;
  logic       ErroControle;
`ifdef DEMUX3_8_CONTADORES_EN
  logic [7:0] Contagem0, Contagem1, Contagem2;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  demux3_8_registrado dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Entrada       (Entrada),
    .Controle      (Controle),
    .EntradaValida (EntradaValida),
    .EntradaPronta (EntradaPronta),
    .Saida0        (Saida0),
    .Saida1        (Saida1),
    .Saida2        (Saida2),
    .SaidaValida   (SaidaValida),
    .SaidaPronta   (SaidaPronta),
    .ErroControle  (ErroControle)
`ifdef DEMUX3_8_CONTADORES_EN
    ,
    .Contagem0     (Contagem0),
    .Contagem1     (Contagem1),
    .Contagem2     (Contagem2)
`endif
  );

  typedef struct {
    logic [7:0] din;
    logic [1:0] ctl;
    logic       v;
    logic [2:0] pr;
    logic       rdy;
    logic [2:0] sv;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       erro;
  } vec_t;

  vec_t tab [12];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] c,
                       input logic v, input logic [2:0] p);
    Entrada       = d;
    Controle      = c;
    EntradaValida = v;
    SaidaPronta   = p;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] sv,
                          input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic erro);
    chk({tag, ".sv"},   32'(SaidaValida),  32'(sv));
    chk({tag, ".s0"},   32'(Saida0),       32'(s0));
    chk({tag, ".s1"},   32'(Saida1),       32'(s1));
    chk({tag, ".s2"},   32'(Saida2),       32'(s2));
    chk({tag, ".erro"}, 32'(ErroControle), 32'(erro));
  endtask

  initial begin
    //          din    ctl    v     pr      rdy   sv      s0     s1     s2     erro
    tab[0]  = '{8'hFF, 2'd0, 1'b1, 3'b000, 1'b1, 3'b001, 8'hFF, 8'h00, 8'h00, 1'b0};
    tab[1]  = '{8'hAA, 2'd0, 1'b1, 3'b000, 1'b0, 3'b001, 8'hFF, 8'h00, 8'h00, 1'b0};
    tab[2]  = '{8'h55, 2'd1, 1'b1, 3'b000, 1'b1, 3'b011, 8'hFF, 8'h55, 8'h00, 1'b0};
    tab[3]  = '{8'h77, 2'd2, 1'b1, 3'b000, 1'b1, 3'b111, 8'hFF, 8'h55, 8'h77, 1'b0};
    tab[4]  = '{8'h00, 2'd2, 1'b1, 3'b100, 1'b1, 3'b111, 8'hFF, 8'h55, 8'h00, 1'b0};
    tab[5]  = '{8'h0F, 2'd2, 1'b1, 3'b100, 1'b1, 3'b111, 8'hFF, 8'h55, 8'h0F, 1'b0};
    tab[6]  = '{8'hEE, 2'd3, 1'b1, 3'b000, 1'b1, 3'b111, 8'hFF, 8'h55, 8'h0F, 1'b1};
    tab[7]  = '{8'h12, 2'd0, 1'b0, 3'b001, 1'b1, 3'b110, 8'hFF, 8'h55, 8'h0F, 1'b1};
    tab[8]  = '{8'h34, 2'd1, 1'b0, 3'b000, 1'b0, 3'b110, 8'hFF, 8'h55, 8'h0F, 1'b1};
    tab[9]  = '{8'h34, 2'd0, 1'b0, 3'b110, 1'b1, 3'b000, 8'hFF, 8'h55, 8'h0F, 1'b1};
    tab[10] = '{8'h9C, 2'd0, 1'b1, 3'b111, 1'b1, 3'b001, 8'h9C, 8'h55, 8'h0F, 1'b1};
    tab[11] = '{8'h3C, 2'd1, 1'b1, 3'b001, 1'b1, 3'b010, 8'h9C, 8'h3C, 8'h0F, 1'b1};

    Reset = 1'b0;
    drive(8'h00, 2'd0, 1'b0, 3'b000);
    #1;
    chk("reset.rdy", 32'(EntradaPronta), 32'd1);
    chk_outs("reset", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      drive(tab[i].din, tab[i].ctl, tab[i].v, tab[i].pr);
      #1;
      chk($sformatf("v%0d.rdy", i), 32'(EntradaPronta), 32'(tab[i].rdy));
      @(posedge Clock);
      #1;
      chk_outs($sformatf("v%0d", i), tab[i].sv,
               tab[i].s0, tab[i].s1, tab[i].s2, tab[i].erro);
    end

    // Fill channels 0 and 2 so all three are full and stalled.
    @(negedge Clock);
    drive(8'h5A, 2'd0, 1'b1, 3'b000);
    @(negedge Clock);
    drive(8'hA5, 2'd2, 1'b1, 3'b000);
    @(posedge Clock);
    #1;
    chk_outs("full", 3'b111, 8'h5A, 8'h3C, 8'hA5, 1'b1);

    // Asynchronous reset mid-cycle, with an offer pending.
    @(negedge Clock);
    #2;
    drive(8'h11, 2'd0, 1'b1, 3'b000);
    Reset = 1'b0;
    #1;
    chk_outs("async_rst", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("async_rst.rdy", 32'(EntradaPronta), 32'd1);
    @(posedge Clock);
    #1;
    chk_outs("rst_hold", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge Clock);
    drive(8'h00, 2'd0, 1'b0, 3'b000);
    Reset = 1'b1;

`ifdef DEMUX3_8_CONTADORES_EN
    for (int i = 0; i < 257; i++) begin
      @(negedge Clock);
      drive(8'(i), 2'd1, 1'b1, 3'b000);
      @(negedge Clock);
      drive(8'(i), 2'd1, 1'b0, 3'b010);
    end
    @(negedge Clock);
    drive(8'h00, 2'd0, 1'b0, 3'b000);
    @(posedge Clock);
    #1;
    chk("cnt0", 32'(Contagem0), 32'd0);
    chk("cnt1", 32'(Contagem1), 32'd1);
    chk("cnt2", 32'(Contagem2), 32'd0);
    chk("cnt.sv", 32'(SaidaValida), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux3_8_registrado.md
# demux3_8_registrado

Registered 1-to-3 demultiplexer for 8-bit datapath values: the write-side counterpart of the 3-input 8-bit selector. It accepts one value per cycle, with a selector, over a valid/ready handshake. The value goes into a one-entry buffer for one of three destination channels. Each channel presents its value to its consumer, such as a register-bank write port or the memory data register, with its own valid/ready handshake.

## Interface
- LARGURA, 8, data width of the input and of each channel
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset (asserted at 0)
- Entrada  input  LARGURA  value to route
- Controle  input  2  destination: 00→channel 0, 01→channel 1, 10→channel 2, 11→invalid
- EntradaValida  input  1  producer offers Entrada/Controle this cycle
- EntradaPronta  output  1  block accepts the offer this cycle (combinational)
- Saida0, Saida1, Saida2  output  LARGURA each  channel data (registered)
- SaidaValida  output  3  bit i: channel i holds undelivered data
- SaidaPronta  input  3  bit i: consumer i takes Saida i this cycle
- ErroControle  output  1  sticky; set when a valid offer carries Controle=11

## Operation
- Each channel is a two-state FSM.
  - VAZIO→CHEIO on a write.
  - CHEIO→VAZIO on a pop without a write.
  - CHEIO→CHEIO on a simultaneous pop and write, with the data replaced.
- Pop for channel i: SaidaValida[i] && SaidaPronta[i].
- EntradaPronta = (Controle==11) || !SaidaValida[c] || SaidaPronta[c], where c = Controle. It does not depend on EntradaValida.
- Write to channel c: EntradaValida && EntradaPronta && Controle!=11. On that edge, Saida c ← Entrada and SaidaValida[c] ← 1.
- Controle=11 with EntradaValida: the offer is consumed and discarded, and ErroControle ← 1. No channel changes. ErroControle clears only on reset.
- Only the selected channel's readiness gates the input. A stalled channel never blocks offers to other channels.
- Saida i holds its last value after a pop; it is never cleared except by reset.
- SaidaPronta on an empty channel has no effect.

## Timing
- Reset (asynchronous, immediate): Saida0..2 = 0, SaidaValida = 000, ErroControle = 0, all channels VAZIO. Any buffered data is discarded.
- While reset is asserted, EntradaPronta follows its equation, but no write takes effect.
- Latency: an offer accepted at edge k is visible on Saida c with SaidaValida[c]=1 right after edge k (1 cycle).
- Throughput: 1 value per cycle, including back-to-back writes to the same channel whose consumer holds SaidaPronta=1.
- A full channel whose consumer is stalled makes EntradaPronta=0 for offers targeting that channel. The producer must hold Entrada/Controle stable until accepted.

## Configuration
- DEMUX3_8_CONTADORES_EN defined: adds outputs Contagem0, Contagem1, Contagem2 (8 bits each).
  - Each counter increments on every pop of its channel and wraps 255→0.
  - Each counter resets to 0.
- DEMUX3_8_CONTADORES_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - LARGURA_DADO = 8
  - Selector constants CANAL_0 = 2'b00, CANAL_1 = 2'b01, CANAL_2 = 2'b10, CANAL_INVALIDO = 2'b11
  - Channel state encoding VAZIO/CHEIO
- Sub-module canal_buffer implements one channel and is instantiated three times.
  - Inputs: write enable, data, pop.
  - Outputs: data, valid, and the optional counter.
- The top level holds the selector decode, EntradaPronta and ErroControle.

## Test plan
- Reset, then offer Entrada=0xFF with Controle=00 and SaidaPronta=000 → Saida0=0xFF and SaidaValida=001 one cycle later. A second offer to channel 0 sees EntradaPronta=0 and is held.
- Channel 0 full and stalled, offer 0x55 with Controle=01 → accepted the same cycle; SaidaValida=011 and Saida1=0x55.
- Channel 2 full, SaidaPronta[2]=1, offer 0x00 then 0x0F on consecutive cycles → both accepted without a bubble; Saida2 shows 0x00 then 0x0F.
- Offer with Controle=11 → EntradaPronta=1, ErroControle=1 from the next cycle, SaidaValida unchanged. ErroControle stays 1 until reset.
- Assert Reset with all channels full → SaidaValida=000, all Saida=0 and ErroControle=0 immediately, without waiting for a clock edge.
- With DEMUX3_8_CONTADORES_EN defined, perform 257 pops on channel 1 → Contagem1=1 (wrap) and Contagem0=Contagem2=0.
